// File: rtl/ms_ws_if.sv
// MEM -> WB handshake: valid, instruction bus and the WB allow-in.
// MEM drives the master side, WB takes the slave side.
interface ms_ws_if #(
  parameter int W = 118
);
  logic         ms_to_ws_valid;
  logic [W-1:0] ms_to_ws_bus;
  logic         ws_allowin;

  modport master (
    output ms_to_ws_valid,
    output ms_to_ws_bus,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid,
    input  ms_to_ws_bus,
    output ws_allowin
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage with CP0 (exceptions, ERET, mtc0/mfc0, interrupts).
// Define CP0_TIMER_EN to enable the Count/Compare timer.
module wb_stage #(
  parameter logic [31:0] EX_ENTRY = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        resetn,
  ms_ws_if.slave      ms,
  input  logic [5:0]  ext_int,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        WS_EX,
  output logic        ERET,
  output logic [31:0] ws_redirect_pc,
  output logic [4:0]  WB_dest,
  output logic [31:0] WB_dest_data,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam logic [4:0] NO_EX = 5'h1f;

  logic         ws_valid_q;
  logic [117:0] bus_q;

  logic [4:0]  rd, exc, dest;
  logic        tlbwi, mfc0, mtc0, pc_err;
  logic        eret, slot, gr_we;
  logic [31:0] badv, result, pc;

  assign {rd, tlbwi, mfc0, mtc0, pc_err,
          badv, exc, eret, slot, gr_we,
          dest, result, pc} = bus_q;

  logic unused_bits;
  assign unused_bits = ^{tlbwi, pc_err};

  assign ms.ws_allowin = 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      ws_valid_q <= ms.ms_to_ws_valid;
      if (ms.ms_to_ws_valid) bus_q <= ms.ms_to_ws_bus;
    end
  end

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d, ie_q, ie_d;
  logic        bd_q, bd_d, ti_q, ti_d;
  logic [5:0]  iphw_q, iphw_d;
  logic [1:0]  ipsw_q, ipsw_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d, badv_q, badv_d;
  logic [31:0] count_q, count_d, cmp_q, cmp_d;

  logic [31:0] status, cause, cp0_rdata;
  logic        int_pend, wr;
  logic [4:0]  code;

  assign status = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause  = {bd_q, ti_q, 14'd0, iphw_q, ipsw_q,
                   1'b0, exc_q, 2'b00};

  assign int_pend = ie_q & ~exl_q &
                    (|({iphw_q, ipsw_q} & im_q));
  assign WS_EX = ws_valid_q & ((exc != NO_EX) | int_pend);
  assign code  = int_pend ? 5'd0 : exc;
  assign ERET  = ws_valid_q & eret & ~WS_EX;
  assign wr    = ws_valid_q & mtc0 & ~WS_EX;

  always_comb begin
    cp0_rdata = 32'd0;
    case (rd)
      5'd8:    cp0_rdata = badv_q;
      5'd9:    cp0_rdata = count_q;
      5'd11:   cp0_rdata = cmp_q;
      5'd12:   cp0_rdata = status;
      5'd13:   cp0_rdata = cause;
      5'd14:   cp0_rdata = epc_q;
      default: cp0_rdata = 32'd0;
    endcase
  end

  // Exception update is applied last so it wins over mtc0/ERET.
  always_comb begin
    im_d   = im_q;
    exl_d  = exl_q;
    ie_d   = ie_q;
    bd_d   = bd_q;
    ipsw_d = ipsw_q;
    exc_d  = exc_q;
    epc_d  = epc_q;
    badv_d = badv_q;
    iphw_d = {ext_int[5] | ti_q, ext_int[4:0]};
    if (wr && rd == 5'd12) begin
      im_d  = result[15:8];
      exl_d = result[1];
      ie_d  = result[0];
    end
    if (wr && rd == 5'd13) ipsw_d = result[9:8];
    if (wr && rd == 5'd14) epc_d = result;
    if (ERET) exl_d = 1'b0;
    if (WS_EX) begin
      exl_d = 1'b1;
      exc_d = code;
      if (!exl_q) begin
        epc_d = slot ? pc - 32'd4 : pc;
        bd_d  = slot;
      end
      if (code == 5'd4 || code == 5'd5) badv_d = badv;
    end
  end

`ifdef CP0_TIMER_EN
  logic tick_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tick_q <= 1'b0;
    else         tick_q <= ~tick_q;
  end

  always_comb begin
    count_d = count_q + {31'd0, tick_q};
    cmp_d   = cmp_q;
    ti_d    = ti_q;
    if (wr && rd == 5'd9) count_d = result;
    if (count_q == cmp_q) ti_d = 1'b1;
    if (wr && rd == 5'd11) begin
      cmp_d = result;
      ti_d  = 1'b0;
    end
  end
`else
  assign count_d = 32'd0;
  assign cmp_d   = 32'd0;
  assign ti_d    = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      im_q    <= '0;
      exl_q   <= 1'b0;
      ie_q    <= 1'b0;
      bd_q    <= 1'b0;
      ti_q    <= 1'b0;
      iphw_q  <= '0;
      ipsw_q  <= '0;
      exc_q   <= '0;
      epc_q   <= '0;
      badv_q  <= '0;
      count_q <= '0;
      cmp_q   <= '0;
    end else begin
      im_q    <= im_d;
      exl_q   <= exl_d;
      ie_q    <= ie_d;
      bd_q    <= bd_d;
      ti_q    <= ti_d;
      iphw_q  <= iphw_d;
      ipsw_q  <= ipsw_d;
      exc_q   <= exc_d;
      epc_q   <= epc_d;
      badv_q  <= badv_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
    end
  end

  assign rf_we    = ws_valid_q & gr_we & ~WS_EX;
  assign rf_waddr = dest;
  assign rf_wdata = mfc0 ? cp0_rdata : result;

  assign ws_redirect_pc = WS_EX ? EX_ENTRY :
                          ERET  ? epc_q : 32'd0;

  assign WB_dest      = dest & {5{ws_valid_q & gr_we}};
  assign WB_dest_data = rf_wdata;

  assign debug_wb_pc       = pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule
